// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with sign handling and RISC-V special-case results.
`timescale 1ns/1ps
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             flush,
   input  logic [2:0]       Funct3,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Result
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PREP  = 3'd1,
      CALC  = 3'd2,
      FIXUP = 3'd3,
      DONE  = 3'd4
   } state_t;

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
      return ~v + ONE_W;
   endfunction

   function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
      return ~v + {ZERO, ONE_W};
   endfunction

   state_t               state_r, state_next;
   logic [2:0]           op_r;
   logic [WIDTH-1:0]     a_r, b_r;
   logic [WIDTH-1:0]     opnd_r;
   logic [2*WIDTH-1:0]   prod_r;
   logic [WIDTH-1:0]     rem_r;
   logic                 neg_res_r;
   logic [CW-1:0]        cnt_r;
   logic [WIDTH-1:0]     result_r;
   logic                 done_r, busy_r;

   logic                 sign_a_en_s, sign_b_en_s, neg_a_s, neg_b_s, neg_res_s;
   logic [WIDTH-1:0]     a_mag_s, b_mag_s;
   logic                 is_div_s, div_zero_s, div_ovf_s, special_s;
   logic [WIDTH-1:0]     special_result_s;
   logic [WIDTH:0]       mul_sum_s, shift_rem_s, div_diff_s;
   logic [2*WIDTH-1:0]   prod_fix_s;
   logic [WIDTH-1:0]     quo_fix_s, rem_fix_s, fix_result_s;

   assign stall  = ((state_r == IDLE) & start) | (state_r == PREP) |
                   (state_r == CALC) | (state_r == FIXUP);
   assign busy   = busy_r;
   assign done   = done_r;
   assign Result = result_r;

   // Operand magnitudes, result sign and RISC-V special-case detection
   always_comb begin
      sign_a_en_s = 1'b0;
      sign_b_en_s = 1'b0;
      case (op_r)
         3'b000, 3'b001, 3'b100, 3'b110: begin
            sign_a_en_s = 1'b1;
            sign_b_en_s = 1'b1;
         end
         3'b010: begin
            sign_a_en_s = 1'b1;
            sign_b_en_s = 1'b0;
         end
         default: begin
            sign_a_en_s = 1'b0;
            sign_b_en_s = 1'b0;
         end
      endcase
      neg_a_s    = sign_a_en_s & a_r[WIDTH-1];
      neg_b_s    = sign_b_en_s & b_r[WIDTH-1];
      a_mag_s    = neg_a_s ? neg_w(a_r) : a_r;
      b_mag_s    = neg_b_s ? neg_w(b_r) : b_r;
      is_div_s   = op_r[2];
      // remainder follows the dividend; products and quotients use signA^signB
      neg_res_s  = (is_div_s & op_r[1]) ? neg_a_s : (neg_a_s ^ neg_b_s);
      div_zero_s = (b_r == ZERO);
      div_ovf_s  = ~op_r[0] & (a_r == MIN_NEG) & (b_r == ONES);
      special_s  = is_div_s & (div_zero_s | div_ovf_s);
      if (div_zero_s) begin
         special_result_s = op_r[1] ? a_r : ONES;
      end else begin
         special_result_s = op_r[1] ? ZERO : MIN_NEG;
      end
   end

   // One iteration of shift-add multiply and restoring divide
   always_comb begin
      mul_sum_s   = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + {1'b0, (prod_r[0] ? opnd_r : ZERO)};
      shift_rem_s = {rem_r, prod_r[WIDTH-1]};
      div_diff_s  = shift_rem_s - {1'b0, opnd_r};
   end

   // Sign fix-up and output selection
   always_comb begin
      prod_fix_s = neg_res_r ? neg_2w(prod_r) : prod_r;
      quo_fix_s  = neg_res_r ? neg_w(prod_r[WIDTH-1:0]) : prod_r[WIDTH-1:0];
      rem_fix_s  = neg_res_r ? neg_w(rem_r) : rem_r;
      if (op_r[2]) begin
         fix_result_s = op_r[1] ? rem_fix_s : quo_fix_s;
      end else begin
         fix_result_s = (op_r[1:0] == 2'b00) ? prod_fix_s[WIDTH-1:0]
                                             : prod_fix_s[2*WIDTH-1:WIDTH];
      end
   end

   // Next-state logic; flush overrides every state
   always_comb begin
      state_next = state_r;
      if (flush) begin
         state_next = IDLE;
      end else begin
         case (state_r)
            IDLE:    state_next = start ? PREP : IDLE;
            PREP:    state_next = special_s ? DONE : CALC;
            CALC:    state_next = (cnt_r == CNT_ONE) ? FIXUP : CALC;
            FIXUP:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // State register and registered status outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_next;
         busy_r  <= (state_next != IDLE);
         done_r  <= (state_next == DONE);
      end
   end

   // Datapath: operand capture, iteration registers and result
   always_ff @(posedge clk) begin
      if (reset) begin
         op_r      <= 3'b000;
         a_r       <= ZERO;
         b_r       <= ZERO;
         opnd_r    <= ZERO;
         prod_r    <= {ZERO, ZERO};
         rem_r     <= ZERO;
         neg_res_r <= 1'b0;
         cnt_r     <= {CW{1'b0}};
         result_r  <= ZERO;
      end else begin
         case (state_r)
            IDLE: begin
               if (start & ~flush) begin
                  op_r <= Funct3;
                  a_r  <= SrcA;
                  b_r  <= SrcB;
               end
            end
            PREP: begin
               opnd_r    <= is_div_s ? b_mag_s : a_mag_s;
               prod_r    <= {ZERO, (is_div_s ? a_mag_s : b_mag_s)};
               rem_r     <= ZERO;
               neg_res_r <= neg_res_s;
               cnt_r     <= CNT_LOAD;
               if (special_s & ~flush) begin
                  result_r <= special_result_s;
               end
            end
            CALC: begin
               cnt_r <= cnt_r - CNT_ONE;
               if (op_r[2]) begin
                  rem_r  <= div_diff_s[WIDTH] ? shift_rem_s[WIDTH-1:0] : div_diff_s[WIDTH-1:0];
                  prod_r <= {prod_r[2*WIDTH-1:WIDTH], prod_r[WIDTH-2:0], ~div_diff_s[WIDTH]};
               end else begin
                  prod_r <= {mul_sum_s, prod_r[WIDTH-1:1]};
               end
            end
            FIXUP: begin
               if (~flush) begin
                  result_r <= fix_result_s;
               end
            end
            DONE: begin
               op_r <= op_r;
            end
            default: begin
               op_r <= op_r;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized and directed bench for muldiv_sequencer against a 64-bit arithmetic
// reference model, covering latency, stall/busy/done timing, flush and reset.
`timescale 1ns/1ps
module tb_muldiv_sequencer;
   localparam int WIDTH = 32;
   localparam logic [31:0] MINV = 32'h8000_0000;
   localparam logic [31:0] ONESV = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset, start, flush;
   logic [2:0]  Funct3;
   logic [31:0] SrcA, SrcB;
   logic        stall, busy, done;
   logic [31:0] Result;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_result;

   always #5 clk = ~clk;

   muldiv_sequencer #(.WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset), .start(start), .flush(flush),
      .Funct3(Funct3), .SrcA(SrcA), .SrcB(SrcB),
      .stall(stall), .busy(busy), .done(done), .Result(Result)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      logic signed [31:0] sa, sb;
      sa = a;
      sb = b;
      case (op)
         3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
         3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
         3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         3'd4: begin
            if (b == 32'd0) return ONESV;
            if (a == MINV && b == ONESV) return MINV;
            return 32'(sa / sb);
         end
         3'd5: return (b == 32'd0) ? ONESV : a / b;
         3'd6: begin
            if (b == 32'd0) return a;
            if (a == MINV && b == ONESV) return 32'd0;
            return 32'(sa % sb);
         end
         default: return (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (!op[2]) return 1'b0;
      if (b == 32'd0) return 1'b1;
      return (!op[0] && a == MINV && b == ONESV);
   endfunction

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return ONESV;
         3: return MINV;
         4: return 32'($urandom_range(0, 255));
         default: return 32'($urandom);
      endcase
   endfunction

   // Issue one op at a negedge with the DUT idle; leaves the DUT idle with start low.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit flush_done);
      int lat, k;
      bit got;
      lat = is_special(op, a, b) ? 2 : 35;
      Funct3 = op; SrcA = a; SrcB = b; start = 1'b1; flush = 1'b0;
      #1;
      check_eq("stall_accept", 32'(stall), 32'd1);
      got = 1'b0;
      for (k = 1; k <= lat + 3; k++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            break;
         end
         check_eq("stall_busy_cycle", 32'(stall), 32'd1);
         SrcA = $urandom; SrcB = $urandom; Funct3 = 3'($urandom_range(0, 7));
      end
      check_eq("done_latency", got ? 32'(k) : 32'd0, 32'(lat));
      if (got) begin
         check_eq("result", Result, exp);
         check_eq("stall_in_done", 32'(stall), 32'd0);
         check_eq("busy_in_done", 32'(busy), 32'd1);
      end
      if (flush_done) flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check_eq("single_done", 32'(done), 32'd0);
      check_eq("idle_after_done", 32'(busy), 32'd0);
      check_eq("result_hold", Result, exp);
      last_result = exp;
      start = 1'b0;
   endtask

   logic [2:0]  d_op  [11] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4};
   logic [31:0] d_a   [11] = '{32'd7, MINV, ONESV, ONESV, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                               32'd100, 32'd100, 32'd5, MINV, MINV};
   logic [31:0] d_b   [11] = '{32'hFFFF_FFFD, MINV, ONESV, ONESV, 32'd2, 32'd2,
                               32'd7, 32'd7, 32'd0, ONESV, ONESV};
   logic [31:0] d_exp [11] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, ONESV,
                               32'hFFFF_FFFD, ONESV, 32'd14, 32'd2, ONESV, 32'd0, MINV};

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [2:0]  op;
      logic [31:0] a, b;
      bit          seen;
      reset = 1'b1; start = 1'b0; flush = 1'b0; Funct3 = 3'd0; SrcA = 32'd0; SrcB = 32'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_eq("reset_result", Result, 32'd0);
      check_eq("reset_busy", 32'(busy), 32'd0);
      check_eq("reset_done", 32'(done), 32'd0);
      check_eq("reset_stall", 32'(stall), 32'd0);

      for (int i = 0; i < 11; i++) run_op(d_op[i], d_a[i], d_b[i], d_exp[i], 1'b0);

      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 7));
         a = pick_val();
         b = pick_val();
         run_op(op, a, b, ref_model(op, a, b), (i % 13) == 5);
      end

      // flush in CALC cycle 10
      Funct3 = 3'd0; SrcA = $urandom; SrcB = $urandom; start = 1'b1;
      repeat (11) @(negedge clk);
      start = 1'b0; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check_eq("flush_stall", 32'(stall), 32'd0);
      check_eq("flush_busy", 32'(busy), 32'd0);
      check_eq("flush_done", 32'(done), 32'd0);
      check_eq("flush_result", Result, last_result);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check_eq("flush_no_late_done", 32'(seen), 32'd0);
      run_op(3'd5, 32'd100, 32'd7, 32'd14, 1'b0);

      // flush and start together in IDLE
      Funct3 = 3'd0; SrcA = 32'd3; SrcB = 32'd3; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check_eq("flush_start_idle_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check_eq("flush_start_idle_busy2", 32'(busy), 32'd0);
      check_eq("flush_start_idle_result", Result, 32'd14);

      // reset mid-CALC
      Funct3 = 3'd1; SrcA = $urandom; SrcB = $urandom; start = 1'b1;
      repeat (10) @(negedge clk);
      reset = 1'b1; start = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      check_eq("midreset_busy", 32'(busy), 32'd0);
      check_eq("midreset_done", 32'(done), 32'd0);
      check_eq("midreset_result", Result, 32'd0);
      run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative RV32M multiply/divide unit with its own sequencing FSM.
- Sits in EX beside the ALU. Accepts an M-extension op from the main controller and raises a pipeline stall while computing.
- Delivers a registered result on a one-cycle done pulse.
- Keeps the single-cycle ALU path free of a 32x32 multiplier and divider.

Parameters:
- WIDTH, 32, operand/result width. Iteration count equals WIDTH; counter width is $clog2(WIDTH)+1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  EX holds an M-extension instruction. Held high by the pipeline while stalled.
- flush  input  1  synchronous abort of the current operation (branch/exception flush).
- Funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcA  input  WIDTH  rs1 operand (multiplicand/dividend).
- SrcB  input  WIDTH  rs2 operand (multiplier/divisor).
- stall  output  1  combinational; freezes PC/IF/ID/EX.
- busy  output  1  registered; high in any state other than IDLE.
- done  output  1  registered; one-cycle pulse, Result valid.
- Result  output  WIDTH  registered result; holds its value until the next DONE.

Behaviour:
- Reset: state=IDLE; Result=0, done=0, busy=0, counter=0, internal registers cleared. Reset mid-operation aborts with no done.
- States: IDLE, PREP, CALC, FIXUP, DONE.
- IDLE:
  - start=1 latches SrcA, SrcB and Funct3, then goes to PREP.
  - Operands are sampled only in this cycle; later changes on SrcA/SrcB are ignored.
- PREP (1 cycle):
  - Compute magnitudes and result sign.
  - Signed: MUL/MULH both operands, MULHSU SrcA only, DIV/REM both.
  - Load counter=WIDTH, then go to CALC.
  - Special cases go straight to DONE with Result loaded:
    - divisor==0: DIV/DIVU give all-ones; REM/REMU give the dividend.
    - DIV with 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM of the same operands gives 0.
- CALC (WIDTH cycles): one bit per cycle, counter decrements, exit to FIXUP when counter reaches 1.
  - Multiply: shift-add into a 2*WIDTH product register.
  - Divide: restoring divide, one quotient bit per cycle, with a WIDTH+1-bit partial remainder.
- FIXUP (1 cycle):
  - Apply sign by two's complement.
    - Product: sign = signA^signB, applied to the full 2*WIDTH product.
    - Quotient: sign = signA^signB.
    - Remainder: takes the dividend's sign.
  - Select the output: MUL low half; MULH/MULHSU/MULHU high half; DIV/DIVU quotient; REM/REMU remainder.
  - Register into Result, then go to DONE.
- DONE (1 cycle): done=1, then go to IDLE. start is ignored here because the same instruction is still in EX and leaves at the end of this cycle.
- Latency (start accepted in cycle T):
  - Normal path: done at T+WIDTH+3 (T+35 for WIDTH=32).
  - Special cases: done at T+2.
- stall = (state==IDLE & start) | (state in PREP, CALC, FIXUP). stall=0 in DONE, so the pipeline advances with Result.
- start is ignored in PREP/CALC/FIXUP/DONE. A new op is accepted only from IDLE.
- flush: any state goes to IDLE next cycle; no done pulse; Result keeps its old value.
  - flush and start together in IDLE: flush wins, nothing is latched.
  - flush in DONE: done still pulses this cycle, then IDLE.
- All arithmetic is modulo 2^WIDTH. No exceptions are raised; overflow and divide-by-zero follow the RISC-V spec values above.

Test Plan:
- MUL SrcA=7, SrcB=0xFFFFFFFD, start at T -> stall high T..T+34, done at T+35, Result=0xFFFFFFEB.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF with done at T+2. REM 0x80000000 % 0xFFFFFFFF -> 0 at T+2. DIV same operands -> 0x80000000.
- flush asserted in CALC cycle 10 -> IDLE next cycle, stall and busy drop, no done, Result unchanged. A new start then completes normally.
- reset asserted mid-CALC -> next cycle busy=0, done=0, Result=0. Back-to-back ops (start held through DONE, then new start in IDLE) -> exactly one done per op.
